// File: rtl/vector_sweep_checker_if.sv
// Stimulus/response and result bundle between vector_sweep_checker and its driver.
// The exp_resp/fail_seen/fail_vec members exist only when FIRST_FAIL_CAPTURE_EN is defined.
interface vector_sweep_checker_if #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 40
);
    logic             start;
    logic             stall;
    logic [OUT_W-1:0] resp_data;
    logic [IN_W-1:0]  stim_vec;
    logic             busy;
    logic             done;
    logic             pass;
    logic [OUT_W-1:0] signature;
    logic [IN_W:0]    vec_count;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic [OUT_W-1:0] exp_resp;
    logic             fail_seen;
    logic [IN_W-1:0]  fail_vec;
`endif

    modport master (
        output start, stall, resp_data,
`ifdef FIRST_FAIL_CAPTURE_EN
        output exp_resp,
        input  fail_seen, fail_vec,
`endif
        input  stim_vec, busy, done, pass, signature, vec_count
    );

    modport slave (
        input  start, stall, resp_data,
`ifdef FIRST_FAIL_CAPTURE_EN
        input  exp_resp,
        output fail_seen, fail_vec,
`endif
        output stim_vec, busy, done, pass, signature, vec_count
    );
endinterface

// File: rtl/vector_sweep_checker.sv
// Incrementing-sweep stimulus engine that compacts LAT-delayed responses into a MISR signature.
// Optional macro FIRST_FAIL_CAPTURE_EN adds per-vector exp_resp comparison with first-failure capture.
module vector_sweep_checker #(
    parameter int               IN_W      = 20,
    parameter int               OUT_W     = 40,
    parameter logic [IN_W-1:0]  START_VEC = 20'h00000,
    parameter logic [IN_W-1:0]  END_VEC   = 20'h0FFFE,
    parameter int               LAT       = 0,
    parameter logic [OUT_W-1:0] POLY      = 40'h0000280005,
    parameter logic [OUT_W-1:0] SEED      = 40'h0,
    parameter logic [OUT_W-1:0] GOLDEN    = 40'h0
) (
    input logic                   clk,
    input logic                   rst,
    vector_sweep_checker_if.slave bus
);
    if (END_VEC < START_VEC) begin : g_range_err
        $error("vector_sweep_checker: END_VEC is below START_VEC");
    end
    if (LAT < 0 || LAT > 3) begin : g_lat_err
        $error("vector_sweep_checker: LAT must be within 0..3");
    end

    // Pipe needs at least one bit even when LAT=0; it is simply unused then.
    localparam int PW = (LAT > 0) ? LAT : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic [OUT_W-1:0] sig_q, sig_d;
    logic [IN_W:0]    cnt_q, cnt_d;
    logic [PW-1:0]    tok_q, tok_d;

    logic start_ok;
    logic advance;
    logic tok_in;
    logic absorb;

    assign start_ok = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    assign advance  = (state_q == S_RUN || state_q == S_DRAIN) && !bus.stall;
    assign tok_in   = (state_q == S_RUN) && !bus.stall;
    assign absorb   = (LAT == 0) ? tok_in : (advance && tok_q[PW-1]);

    always_comb begin
        tok_d = tok_q;
        if (start_ok) begin
            tok_d = '0;
        end else if (advance) begin
            tok_d[0] = tok_in;
            for (int i = 1; i < PW; i++) begin
                tok_d[i] = tok_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    stim_d  = START_VEC;
                    sig_d   = SEED;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // The END_VEC token enters this edge; the counter parks there so it never wraps.
                if (!bus.stall) begin
                    if (stim_q == END_VEC) begin
                        state_d = (LAT == 0) ? S_DONE : S_DRAIN;
                    end else begin
                        stim_d = stim_q + IN_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.stall && tok_d == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (absorb) begin
            sig_d = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? POLY : '0) ^ bus.resp_data;
            cnt_d = cnt_q + (IN_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            tok_q   <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            tok_q   <= tok_d;
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    // Stimulus travels alongside its token so a failure can be blamed on the right vector.
    logic [PW-1:0][IN_W-1:0] vpipe_q, vpipe_d;
    logic                    fail_seen_q, fail_seen_d;
    logic [IN_W-1:0]         fail_vec_q, fail_vec_d;
    logic [IN_W-1:0]         abs_vec;

    assign abs_vec = (LAT == 0) ? stim_q : vpipe_q[PW-1];

    always_comb begin
        vpipe_d = vpipe_q;
        if (advance) begin
            vpipe_d[0] = stim_q;
            for (int i = 1; i < PW; i++) begin
                vpipe_d[i] = vpipe_q[i-1];
            end
        end
    end

    always_comb begin
        fail_seen_d = fail_seen_q;
        fail_vec_d  = fail_vec_q;
        if (start_ok) begin
            fail_seen_d = 1'b0;
            fail_vec_d  = '0;
        end else if (absorb && !fail_seen_q && bus.resp_data != bus.exp_resp) begin
            fail_seen_d = 1'b1;
            fail_vec_d  = abs_vec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe_q     <= '0;
            fail_seen_q <= 1'b0;
            fail_vec_q  <= '0;
        end else begin
            vpipe_q     <= vpipe_d;
            fail_seen_q <= fail_seen_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    assign bus.fail_seen = fail_seen_q;
    assign bus.fail_vec  = fail_vec_q;
    assign bus.pass      = (state_q == S_DONE) && (sig_q == GOLDEN) && !fail_seen_q;
`else
    assign bus.pass      = (state_q == S_DONE) && (sig_q == GOLDEN);
`endif

    assign bus.stim_vec  = stim_q;
    assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.signature = sig_q;
    assign bus.vec_count = cnt_q;
endmodule

// File: tb/tb_vector_sweep_checker.sv
// Directed bench for vector_sweep_checker: several parameterisations share one clock and reset.
// Cycle counts n run from the cycle start is driven (n=0) to the first cycle with done=1.
module tb_vector_sweep_checker;
    localparam logic [39:0] POLY = 40'h0000280005;

    function automatic logic [39:0] resp_of(input logic [19:0] v);
        return {v ^ 20'hA5C3F, v + 20'h12345};
    endfunction

    function automatic logic [39:0] misr_step(input logic [39:0] s, input logic [39:0] r);
        return {s[38:0], 1'b0} ^ (s[39] ? POLY : 40'h0) ^ r;
    endfunction

    function automatic logic [39:0] misr_ref(input int first, input int last);
        logic [39:0] s;
        s = 40'h0;
        for (int v = first; v <= last; v++) begin
            s = misr_step(s, resp_of(v[19:0]));
        end
        return s;
    endfunction

    localparam logic [39:0] G2 = misr_ref(0, 3);
    localparam logic [39:0] G3 = misr_ref(0, 7);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vector_sweep_checker_if if0 ();
    vector_sweep_checker_if if1 ();
    vector_sweep_checker_if if2 ();
    vector_sweep_checker_if if3 ();

    vector_sweep_checker #(.END_VEC(20'h0), .LAT(0), .GOLDEN(40'h1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    vector_sweep_checker #(.END_VEC(20'h1), .LAT(0), .GOLDEN(40'h0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    vector_sweep_checker #(.END_VEC(20'h3), .LAT(2), .GOLDEN(G2))    u2 (.clk(clk), .rst(rst), .bus(if2));
    vector_sweep_checker #(.END_VEC(20'h7), .LAT(0), .GOLDEN(G3))    u3 (.clk(clk), .rst(rst), .bus(if3));

    // Model of a combinational block followed by two register stages for the LAT=2 instance.
    logic [39:0] d1 = 40'h0;
    logic [39:0] d2 = 40'h0;
    always @(posedge clk) begin
        d1 <= resp_of(if2.stim_vec);
        d2 <= d1;
    end

    assign if0.resp_data = 40'h1;
    assign if1.resp_data = 40'h1;
    assign if2.resp_data = d2;
    assign if3.resp_data = resp_of(if3.stim_vec);

`ifdef FIRST_FAIL_CAPTURE_EN
    vector_sweep_checker_if if4 ();
    vector_sweep_checker #(.END_VEC(20'h7), .LAT(0), .GOLDEN(G3)) u4 (.clk(clk), .rst(rst), .bus(if4));
    assign if0.exp_resp  = 40'h1;
    assign if1.exp_resp  = 40'h1;
    assign if2.exp_resp  = d2;
    assign if3.exp_resp  = resp_of(if3.stim_vec);
    assign if4.resp_data = resp_of(if4.stim_vec);
    assign if4.exp_resp  = resp_of(if4.stim_vec) ^ ((if4.stim_vec == 20'h4) ? 40'h1 : 40'h0);
`endif

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if0.stim_vec !== 20'h0) begin errors++; $display("FAIL reset_stim: got %h want 0", if0.stim_vec); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", if0.busy); end
        checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", if0.done); end
        checks++; if (if0.pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", if0.pass); end
        checks++; if (if0.signature !== 40'h0) begin errors++; $display("FAIL reset_sig: got %h want 0", if0.signature); end
        checks++; if (if0.vec_count !== 21'h0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", if0.vec_count); end
        $display("reset: stim=%h busy=%b done=%b sig=%h cnt=%0d", if0.stim_vec, if0.busy, if0.done, if0.signature, if0.vec_count);
        rst = 1'b0;
    endtask

    task automatic test_single_vector;
        int n;
        @(posedge clk); #1;
        if0.start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if0.start = 1'b0;
            n++;
            if (n == 1) begin
                checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", if0.busy); end
            end
        end while (if0.done !== 1'b1 && n < 40);
        checks++; if (n != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", n); end
        checks++; if (if0.signature !== 40'h1) begin errors++; $display("FAIL single_sig: got %h want 1", if0.signature); end
        checks++; if (if0.vec_count !== 21'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", if0.vec_count); end
        checks++; if (if0.pass !== 1'b1) begin errors++; $display("FAIL single_pass: got %b want 1", if0.pass); end
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", if0.busy); end
        $display("single_vector: n=%0d sig=%h cnt=%0d pass=%b", n, if0.signature, if0.vec_count, if0.pass);
    endtask

    task automatic test_two_vectors;
        int n;
        @(posedge clk); #1;
        if1.start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if1.start = 1'b0;
            n++;
        end while (if1.done !== 1'b1 && n < 40);
        checks++; if (n != 3) begin errors++; $display("FAIL two_latency: got %0d want 3", n); end
        checks++; if (if1.signature !== 40'h3) begin errors++; $display("FAIL two_sig: got %h want 3", if1.signature); end
        checks++; if (if1.vec_count !== 21'd2) begin errors++; $display("FAIL two_cnt: got %0d want 2", if1.vec_count); end
        checks++; if (if1.pass !== 1'b0) begin errors++; $display("FAIL two_pass: got %b want 0", if1.pass); end
        checks++; if (if1.stim_vec !== 20'h1) begin errors++; $display("FAIL two_stim_hold: got %h want 1", if1.stim_vec); end
        $display("two_vectors: n=%0d sig=%h cnt=%0d pass=%b", n, if1.signature, if1.vec_count, if1.pass);
    endtask

    task automatic test_latency;
        int n;
        @(posedge clk); #1;
        if2.start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if2.start = 1'b0;
            n++;
            if (n == 5) begin
                // In DRAIN: sweep parked at END_VEC, two responses still in flight.
                checks++; if (if2.busy !== 1'b1) begin errors++; $display("FAIL lat_drain_busy: got %b want 1", if2.busy); end
                checks++; if (if2.vec_count !== 21'd2) begin errors++; $display("FAIL lat_drain_cnt: got %0d want 2", if2.vec_count); end
                checks++; if (if2.stim_vec !== 20'h3) begin errors++; $display("FAIL lat_drain_stim: got %h want 3", if2.stim_vec); end
            end
        end while (if2.done !== 1'b1 && n < 40);
        checks++; if (n != 7) begin errors++; $display("FAIL lat_latency: got %0d want 7", n); end
        checks++; if (if2.vec_count !== 21'd4) begin errors++; $display("FAIL lat_cnt: got %0d want 4", if2.vec_count); end
        checks++; if (if2.signature !== G2) begin errors++; $display("FAIL lat_sig: got %h want %h", if2.signature, G2); end
        checks++; if (if2.pass !== 1'b1) begin errors++; $display("FAIL lat_pass: got %b want 1", if2.pass); end
        $display("latency: n=%0d sig=%h cnt=%0d pass=%b", n, if2.signature, if2.vec_count, if2.pass);
    endtask

    task automatic test_sweep;
        int n;
        @(posedge clk); #1;
        if3.start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if3.start = 1'b0;
            n++;
        end while (if3.done !== 1'b1 && n < 60);
        checks++; if (n != 9) begin errors++; $display("FAIL sweep_latency: got %0d want 9", n); end
        checks++; if (if3.signature !== G3) begin errors++; $display("FAIL sweep_sig: got %h want %h", if3.signature, G3); end
        checks++; if (if3.vec_count !== 21'd8) begin errors++; $display("FAIL sweep_cnt: got %0d want 8", if3.vec_count); end
        checks++; if (if3.pass !== 1'b1) begin errors++; $display("FAIL sweep_pass: got %b want 1", if3.pass); end
        checks++; if (if3.stim_vec !== 20'h7) begin errors++; $display("FAIL sweep_stim_hold: got %h want 7", if3.stim_vec); end
        $display("sweep: n=%0d sig=%h cnt=%0d pass=%b", n, if3.signature, if3.vec_count, if3.pass);
    endtask

    task automatic test_stall;
        int          n;
        bit          stalled;
        logic [39:0] held_sig;
        @(posedge clk); #1;
        if3.start = 1'b1;
        n = 0;
        stalled = 1'b0;
        do begin
            @(posedge clk); #1;
            if3.start = 1'b0;
            n++;
            if (n == 1) begin
                checks++; if (if3.done !== 1'b0) begin errors++; $display("FAIL stall_done_cleared: got %b want 0", if3.done); end
            end
            if (!stalled && if3.stim_vec == 20'h2) begin
                held_sig = if3.signature;
                if3.stall = 1'b1;
                repeat (3) begin
                    @(posedge clk); #1;
                    n++;
                    checks++; if (if3.stim_vec !== 20'h2) begin errors++; $display("FAIL stall_stim_hold: got %h want 2", if3.stim_vec); end
                    checks++; if (if3.signature !== held_sig) begin errors++; $display("FAIL stall_sig_hold: got %h want %h", if3.signature, held_sig); end
                end
                if3.stall = 1'b0;
                stalled = 1'b1;
            end
        end while (if3.done !== 1'b1 && n < 60);
        checks++; if (n != 12) begin errors++; $display("FAIL stall_latency: got %0d want 12", n); end
        checks++; if (if3.signature !== G3) begin errors++; $display("FAIL stall_sig: got %h want %h", if3.signature, G3); end
        checks++; if (if3.vec_count !== 21'd8) begin errors++; $display("FAIL stall_cnt: got %0d want 8", if3.vec_count); end
        $display("stall: n=%0d sig=%h cnt=%0d", n, if3.signature, if3.vec_count);
    endtask

    task automatic test_start_with_stall;
        int n;
        @(posedge clk); #1;
        if3.start = 1'b1;
        if3.stall = 1'b1;
        @(posedge clk); #1;
        if3.start = 1'b0;
        checks++; if (if3.busy !== 1'b1) begin errors++; $display("FAIL sws_busy: got %b want 1", if3.busy); end
        checks++; if (if3.stim_vec !== 20'h0) begin errors++; $display("FAIL sws_first_vec: got %h want 0", if3.stim_vec); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (if3.stim_vec !== 20'h0) begin errors++; $display("FAIL sws_vec_hold: got %h want 0", if3.stim_vec); end
        checks++; if (if3.vec_count !== 21'd0) begin errors++; $display("FAIL sws_cnt_hold: got %0d want 0", if3.vec_count); end
        if3.stall = 1'b0;
        n = 3;
        do begin
            @(posedge clk); #1;
            n++;
        end while (if3.done !== 1'b1 && n < 60);
        checks++; if (n != 11) begin errors++; $display("FAIL sws_latency: got %0d want 11", n); end
        checks++; if (if3.signature !== G3) begin errors++; $display("FAIL sws_sig: got %h want %h", if3.signature, G3); end
        $display("start_with_stall: n=%0d sig=%h", n, if3.signature);
    endtask

    task automatic test_reset_mid;
        int n;
        @(posedge clk); #1;
        if3.start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if3.start = 1'b0;
            n++;
        end while (if3.stim_vec !== 20'h5 && n < 40);
        checks++; if (if3.stim_vec !== 20'h5) begin errors++; $display("FAIL rmid_reach: got %h want 5", if3.stim_vec); end
        #2 rst = 1'b1;
        #1;
        checks++; if (if3.stim_vec !== 20'h0) begin errors++; $display("FAIL rmid_stim: got %h want 0", if3.stim_vec); end
        checks++; if (if3.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", if3.busy); end
        checks++; if (if3.signature !== 40'h0) begin errors++; $display("FAIL rmid_sig: got %h want 0", if3.signature); end
        checks++; if (if3.vec_count !== 21'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", if3.vec_count); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (if3.done !== 1'b0 || if3.pass !== 1'b0) begin errors++; $display("FAIL rmid_done_pass: got %b%b want 00", if3.done, if3.pass); end
        rst = 1'b0;
        @(posedge clk); #1;
        if3.start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if3.start = 1'b0;
            n++;
        end while (if3.done !== 1'b1 && n < 60);
        checks++; if (if3.signature !== G3) begin errors++; $display("FAIL rmid_rerun_sig: got %h want %h", if3.signature, G3); end
        checks++; if (if3.vec_count !== 21'd8) begin errors++; $display("FAIL rmid_rerun_cnt: got %0d want 8", if3.vec_count); end
        $display("reset_mid: rerun n=%0d sig=%h cnt=%0d", n, if3.signature, if3.vec_count);
    endtask

`ifdef FIRST_FAIL_CAPTURE_EN
    task automatic test_fail_capture;
        int n;
        checks++; if (if4.fail_seen !== 1'b0) begin errors++; $display("FAIL fc_reset: got %b want 0", if4.fail_seen); end
        @(posedge clk); #1;
        if4.start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if4.start = 1'b0;
            n++;
        end while (if4.done !== 1'b1 && n < 60);
        checks++; if (if4.fail_seen !== 1'b1) begin errors++; $display("FAIL fc_seen: got %b want 1", if4.fail_seen); end
        checks++; if (if4.fail_vec !== 20'h4) begin errors++; $display("FAIL fc_vec: got %h want 4", if4.fail_vec); end
        checks++; if (if4.signature !== G3) begin errors++; $display("FAIL fc_sig: got %h want %h", if4.signature, G3); end
        checks++; if (if4.pass !== 1'b0) begin errors++; $display("FAIL fc_pass: got %b want 0", if4.pass); end
        $display("fail_capture: seen=%b vec=%h pass=%b", if4.fail_seen, if4.fail_vec, if4.pass);
    endtask
`endif

    initial begin
        if0.start = 1'b0; if0.stall = 1'b0;
        if1.start = 1'b0; if1.stall = 1'b0;
        if2.start = 1'b0; if2.stall = 1'b0;
        if3.start = 1'b0; if3.stall = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
        if4.start = 1'b0; if4.stall = 1'b0;
`endif
        test_reset();
        test_single_vector();
        test_two_vectors();
        test_latency();
        test_sweep();
        test_stall();
        test_start_with_stall();
        test_reset_mid();
`ifdef FIRST_FAIL_CAPTURE_EN
        test_fail_capture();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vector_sweep_checker.md
Name: vector_sweep_checker

Overview:
- Sequential stimulus/response engine for the 20-in/40-out combinational logic blocks under optimization.
- Drives an incrementing input sweep into the block and samples each 40-bit response after a fixed latency.
- Compacts the responses into a MISR signature and compares it against a golden value, so pre- and post-optimization netlists can be checked for equivalence in hardware without a text dump.

Parameters:
- IN_W, 20, stimulus width
- OUT_W, 40, response width; also MISR width
- START_VEC, 20'h00000, first vector issued
- END_VEC, 20'h0FFFE, last vector issued, inclusive; END_VEC < START_VEC is an elaboration-time $error
- LAT, 0, response latency in cycles, legal range 0..3
- POLY, 40'h0000280005, MISR feedback taps (x^40+x^21+x^19+x^2+1)
- SEED, 40'h0, MISR value loaded on start
- GOLDEN, 40'h0, expected final signature

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE
- stall  in  1  freezes the sweep while high
- resp_data  in  OUT_W  response from the block under test
- stim_vec  out  IN_W  registered stimulus to the block under test
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; held until the next start
- pass  out  1  valid only while done=1; 1 when signature==GOLDEN
- signature  out  OUT_W  current MISR value
- vec_count  out  IN_W+1  number of responses absorbed so far

Behaviour:
- Reset: state=IDLE; stim_vec=0, busy=0, done=0, pass=0, signature=0, vec_count=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE on start (sampled at edge k):
  - Next state RUN.
  - stim_vec=START_VEC, signature=SEED, vec_count=0.
  - done and pass are cleared.
- start while busy: ignored.
- RUN, per non-stalled cycle:
  - stim_vec increments by 1.
  - A valid token enters a LAT-deep shift register. For LAT=0 the token is immediate.
  - When stim_vec==END_VEC on a non-stalled cycle, stim_vec holds and the next state is DRAIN. For LAT=0 the next state is DONE directly.
- DRAIN: lasts until all LAT outstanding tokens are absorbed, then DONE.
- Absorb, on each non-stalled cycle where a token exits the pipe:
  - signature <= {signature[OUT_W-2:0],1'b0} ^ (signature[OUT_W-1] ? POLY : 0) ^ resp_data.
  - vec_count increments.
- resp_data contract: sampled LAT cycles after the matching stim_vec value is first presented.
- Latency: with no stalls, start-edge to done=1 is N+LAT+1 cycles, where N=END_VEC-START_VEC+1.
- DONE: done=1; pass=(signature==GOLDEN); stim_vec holds END_VEC.
- stall=1:
  - In RUN/DRAIN: stim_vec, the token pipe, signature and vec_count all freeze.
  - In IDLE/DONE: no effect.
  - A start that coincides with stall is still honoured. The first vector is issued, then holds until stall drops.
- END_VEC=20'hFFFFF: the counter must not wrap; vec_count is IN_W+1 bits so N=2^20 is representable.
- Reset mid-operation: immediate return to all reset values. No partial signature is retained.

Optional Feature:
- Macro FIRST_FAIL_CAPTURE_EN.
- Defined:
  - Adds input exp_resp [OUT_W], aligned with resp_data.
  - Adds outputs fail_seen [1] and fail_vec [IN_W].
  - On the first absorbed response with resp_data != exp_resp, fail_seen is set and fail_vec latches the stimulus that produced it.
  - Both are sticky until start or rst; reset value 0.
  - pass additionally requires fail_seen=0.
- Undefined:
  - Ports and logic are absent.
  - pass depends only on the signature.

Test Plan:
- START_VEC=0, END_VEC=0, LAT=0, resp_data=40'h1, start -> done after 2 cycles, signature=40'h1, vec_count=1, pass=1 with GOLDEN=40'h1.
- END_VEC=1, LAT=0, resp_data=40'h1 constant -> signature=40'h3, vec_count=2; GOLDEN=40'h0 gives pass=0.
- LAT=2, END_VEC=3, resp_data driven from stim_vec delayed 2 cycles -> done exactly 7 cycles after start, vec_count=4, signature matches the reference model.
- Stall held 3 cycles mid-RUN at stim_vec=20'h00002 -> stim_vec and signature hold for 3 cycles; final signature is identical to the unstalled run and done arrives 3 cycles later.
- rst asserted at stim_vec=20'h00005, then start re-issued -> all outputs read 0 during reset; the rerun signature equals a clean run.
- FIRST_FAIL_CAPTURE_EN defined, exp_resp differs only for vector 20'h00004 -> fail_seen=1, fail_vec=20'h00004, pass=0 at done.
